// File: rtl/device_fetch.sv
// Instruction fetch stage: issues synchronous reads at the current PC and buffers
// returned words in a 2-entry queue tagged with PC and out-of-range fault.
module device_fetch #(
  parameter int PC_BITS        = 8,
  parameter int INST_BITS      = 16,
  parameter int INST_MEM_DEPTH = 56
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic [PC_BITS-1:0]   i_pc,
  output logic                 o_pc_advance,
  output logic                 o_mem_en,
  output logic [PC_BITS-1:0]   o_mem_addr,
  input  logic [INST_BITS-1:0] i_mem_data,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [INST_BITS-1:0] o_inst,
  output logic [PC_BITS-1:0]   o_pc,
  output logic                 o_fault
);

  // One extra bit so a depth of exactly 2^PC_BITS still compares correctly
  localparam logic [PC_BITS:0] DEPTH = INST_MEM_DEPTH[PC_BITS:0];

  logic [1:0]           count;
  logic                 inflight;
  logic [PC_BITS-1:0]   inflight_pc;
  logic                 inflight_fault;

  logic [INST_BITS-1:0] tail_inst;
  logic [PC_BITS-1:0]   tail_pc;
  logic                 tail_fault;

  logic                 pc_in_range;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [2:0]           occupancy;
  logic [2:0]           limit;
  logic [INST_BITS-1:0] resp_inst;

  assign pc_in_range = ({1'b0, i_pc} < DEPTH);
  assign o_valid     = (count != 2'd0);
  assign pop         = o_valid & i_ready;
  assign push        = inflight & ~i_flush;

  // Buffered plus in-flight work, net of the entry leaving this cycle, must stay below 2
  assign occupancy   = {1'b0, count} + {2'b00, inflight};
  assign limit       = 3'd2 + {2'b00, pop};
  assign issue       = ~i_flush & (occupancy < limit);

  assign o_pc_advance = i_nrst & issue;
  assign o_mem_en     = i_nrst & issue & pc_in_range;
  assign o_mem_addr   = i_nrst ? i_pc : '0;

  // Faulting fetches never read memory, so whatever sits on the data bus is ignored
  assign resp_inst = inflight_fault ? '0 : i_mem_data;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      count          <= 2'd0;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_fault <= 1'b0;
      o_inst         <= '0;
      o_pc           <= '0;
      o_fault        <= 1'b0;
      tail_inst      <= '0;
      tail_pc        <= '0;
      tail_fault     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= i_pc;
        inflight_fault <= ~pc_in_range;
      end

      if (i_flush) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (count == 2'd2) begin
              o_inst     <= tail_inst;
              o_pc       <= tail_pc;
              o_fault    <= tail_fault;
              tail_inst  <= resp_inst;
              tail_pc    <= inflight_pc;
              tail_fault <= inflight_fault;
            end else begin
              o_inst  <= resp_inst;
              o_pc    <= inflight_pc;
              o_fault <= inflight_fault;
            end
          end
          2'b10: begin
            if (count == 2'd0) begin
              o_inst  <= resp_inst;
              o_pc    <= inflight_pc;
              o_fault <= inflight_fault;
            end else begin
              tail_inst  <= resp_inst;
              tail_pc    <= inflight_pc;
              tail_fault <= inflight_fault;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            o_inst  <= tail_inst;
            o_pc    <= tail_pc;
            o_fault <= tail_fault;
            count   <= count - 2'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
